e_mdu: RTL
==========

# e_mdu

Multiply/divide unit of the E stage in the 5-stage MIPS pipeline. Consumes the instruction decode and the forwarded rs/rt operands delivered by the D/E pipeline register, runs multi-cycle mult/multu/div/divu with a fixed latency, and holds the architectural HI/LO registers. Exposes a busy indication to the hazard unit so D-stage multiply/divide instructions stall while an operation is in flight.

## Interface
Parameters:
- MULT_LAT, 5, cycles from start edge to HI/LO commit for mult/multu
- DIV_LAT, 10, cycles from start edge to HI/LO commit for div/divu

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high; one clock; sampled on posedge clk
- md_op  in  4  E-stage operation code: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
- rs_d  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- rt_d  in  32  forwarded rt operand (divisor / multiplier)
- start  out  1  combinational: md_op is MD_MULT/MULTU/DIV/DIVU and busy==0
- busy  out  1  registered: operation in flight
- md_stall  out  1  start | busy; hazard-unit input
- md_out  out  32  combinational: HI when md_op==MD_MFHI, LO when MD_MFLO, else 0
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- State: IDLE, RUN. Registers: busy, cnt (4 bits), op latch, hi_res/lo_res latch, hi, lo.
- IDLE, start=1 at edge: latch op and computed result (hi_res/lo_res), cnt <= MULT_LAT-1 or DIV_LAT-1, busy <= 1, enter RUN.
- RUN: cnt decrements each edge; at edge where cnt==0: hi<=hi_res, lo<=lo_res, busy<=0, return IDLE.
- mult: signed 32x32 -> 64; {hi,lo} = product. multu: unsigned.
- div: signed, quotient truncates toward zero -> lo; remainder takes dividend sign -> hi. divu: unsigned.
- Divide by zero (rt_d==0): operation still occupies DIV_LAT cycles; HI/LO unchanged at commit.
- mthi/mtlo: at edge with busy==0, hi<=rs_d or lo<=rs_d. Ignored while busy (hazard unit must prevent).
- md_op of a mult/div class while busy: ignored (start=0); no restart, no relatch.
- mfhi/mflo read committed HI/LO only; never in-flight results.

## Timing
- Reset values: hi=0, lo=0, busy=0, cnt=0, state IDLE; start/md_stall/md_out follow combinationally (0 for MD_NONE).
- start sampled at edge E0; busy high from E0 through E0+N-1 edges inclusive, i.e. exactly N cycles; HI/LO visible after edge E0+N, same edge busy falls (N=MULT_LAT or DIV_LAT).
- Back-to-back: new start accepted in the cycle after busy falls (earliest edge E0+N+1).
- md_stall high in the start cycle and all N busy cycles.
- Reset asserted mid-operation: abort at that edge; pending result discarded; all registers to reset values.
- Operands are sampled only at the start edge; rs_d/rt_d changes during RUN have no effect.

## Structure
- const.v: MD_* operation codes (4-bit defines); E-stage consumers share them.
- MULT_LAT/DIV_LAT stay module parameters, not package constants.
- No sub-module; a single module with the result compute, latency counter and HI/LO registers.

## Test plan
- Reset, then md_op=MD_MULT, rs_d=0xFFFFFFFF, rt_d=2 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MD_MULTU same operands -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; md_stall high 6 cycles total incl. start cycle.
- MD_DIV rs_d=0xFFFFFFF9 (-7), rt_d=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; MD_DIVU rs_d=7, rt_d=2 -> lo=3, hi=1.
- MD_MTHI rs_d=0x12345678 then MD_DIV with rt_d=0 -> busy 10 cycles, hi stays 0x12345678, lo unchanged; MD_MFHI -> md_out=0x12345678.
- MD_MULT issued, second MD_DIV and MD_MTLO presented during busy -> both ignored; only mult result committed.
- MD_DIV started, reset at cycle 4 -> busy=0, hi=lo=0 next cycle; no later commit.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// E-stage multiply/divide shared types: operation codes, FSM states, result pair.
// Pure declarations; no latency of its own.
// No flow control here; consumers decide when an op code is honoured.
package e_mdu_pkg;

  // E-stage multiply/divide operation codes, shared by all E-stage consumers
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // HI/LO pair as produced by one multiply or divide
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  // Divide-class op codes (div/divu)
  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Op codes that occupy the unit for a multi-cycle operation
  function automatic logic md_is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> multiply/divide unit bundle: decode/operands in, status and HI/LO out.
// Wires only; no latency.
// busy/md_stall carry the hold-off back to the hazard unit.
interface e_mdu_if;
  logic [3:0]  md_op;
  logic [31:0] rs_d;
  logic [31:0] rt_d;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side: presents the operation and operands
  modport master (
    output md_op, rs_d, rt_d,
    input  start, busy, md_stall, md_out, hi, lo
  );

  // Multiply/divide unit side
  modport slave (
    input  md_op, rs_d, rt_d,
    output start, busy, md_stall, md_out, hi, lo
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit holding the architectural HI/LO registers.
// Latency: HI/LO commit MULT_LAT (mult/multu) or DIV_LAT (div/divu) edges after the start edge.
// Backpressure: busy/md_stall hold D-stage md ops; arith/mthi/mtlo ops presented while busy are dropped.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave md
);

  // Counter reload values: the counter runs N-1 .. 0, committing on the edge it reads 0
  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  md_state_e   state;
  logic        busy_q;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  md_res_t     res_q;
  logic        den_zero_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        start_w;
  logic        den_zero;
  logic [31:0] den;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] num_mag;
  logic [31:0] den_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  md_res_t     res_next;

  // Result compute from the live operands; only the value at the start edge is latched
  always_comb begin
    den_zero = (md.rt_d == 32'd0);
    // Substitute a harmless divisor on divide-by-zero; the result is discarded at commit
    den      = den_zero ? 32'd1 : md.rt_d;

    prod_s = $signed({{32{md.rs_d[31]}}, md.rs_d}) * $signed({{32{md.rt_d[31]}}, md.rt_d});
    prod_u = {32'd0, md.rs_d} * {32'd0, md.rt_d};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend.
    // -2^31 / -1 wraps to quotient 0x80000000, remainder 0.
    num_mag = md.rs_d[31] ? (32'd0 - md.rs_d) : md.rs_d;
    den_mag = den[31] ? (32'd0 - den) : den;
    q_mag   = num_mag / den_mag;
    r_mag   = num_mag % den_mag;

    res_next = '0;
    case (md.md_op)
      MD_MULT:  res_next = prod_s;
      MD_MULTU: res_next = prod_u;
      MD_DIV: begin
        res_next.lo = (md.rs_d[31] ^ den[31]) ? (32'd0 - q_mag) : q_mag;
        res_next.hi = md.rs_d[31] ? (32'd0 - r_mag) : r_mag;
      end
      MD_DIVU: begin
        res_next.lo = md.rs_d / den;
        res_next.hi = md.rs_d % den;
      end
      default:  res_next = '0;
    endcase
  end

  // Issue decode and externally visible status
  always_comb begin
    start_w     = md_is_arith(md.md_op) && !busy_q;
    md.start    = start_w;
    md.busy     = busy_q;
    md.md_stall = start_w | busy_q;
    md.hi       = hi_q;
    md.lo       = lo_q;
    md.md_out   = 32'd0;
    if (md.md_op == MD_MFHI)      md.md_out = hi_q;
    else if (md.md_op == MD_MFLO) md.md_out = lo_q;
  end

  // Control FSM: latch op/result on start, count down, commit HI/LO at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      cnt        <= 4'd0;
      op_q       <= MD_NONE;
      res_q      <= '0;
      den_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_w) begin
            op_q       <= md.md_op;
            res_q      <= res_next;
            den_zero_q <= den_zero;
            cnt        <= md_is_div(md.md_op) ? DIV_CNT : MULT_CNT;
            busy_q     <= 1'b1;
            state      <= ST_RUN;
          end else if (md.md_op == MD_MTHI) begin
            hi_q <= md.rs_d;
          end else if (md.md_op == MD_MTLO) begin
            lo_q <= md.rs_d;
          end
        end
        ST_RUN: begin
          if (cnt == 4'd0) begin
            // Divide by zero still burns the full latency but leaves HI/LO alone
            if (!(md_is_div(op_q) && den_zero_q)) begin
              hi_q <= res_q.hi;
              lo_q <= res_q.lo;
            end
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
